// File: rtl/gadget_sprite_ctrl.sv
// Falling power-up gadget manager: spawn, per-frame fall, paddle catch, off-screen retire,
// and a registered per-pixel lookup that drives the gadget sprite ROM.
module gadget_sprite_ctrl #(
   parameter int NUM_SLOTS   = 4,
   parameter int SPRITE_SIZE = 32,
   parameter int FALL_STEP   = 2,
   parameter int SCREEN_H    = 480,
   parameter int PADDLE_Y    = 440
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_tick,
   input  logic        spawn_valid,
   output logic        spawn_ready,
   input  logic [3:0]  spawn_type,
   input  logic [9:0]  spawn_x,
   input  logic [9:0]  spawn_y,
   input  logic [9:0]  paddle_x,
   input  logic [9:0]  paddle_w,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic [18:0] rom_addr,
   output logic [3:0]  rom_type,
   output logic        pixel_hit,
   output logic        caught_valid,
   output logic [3:0]  caught_type,
   output logic [2:0]  active_count
);

   localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [10:0] SIZE11   = 11'(SPRITE_SIZE);
   localparam logic [10:0] STEP11   = 11'(FALL_STEP);
   localparam logic [10:0] SCREEN11 = 11'(SCREEN_H);
   localparam logic [10:0] PADDLE11 = 11'(PADDLE_Y);

   typedef enum logic {IDLE, UPDATE} state_t;

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic              pending_reg, pending_next;

   logic [NUM_SLOTS-1:0] valid_reg;
   logic [3:0]           type_reg [NUM_SLOTS];
   logic [9:0]           x_reg    [NUM_SLOTS];
   logic [9:0]           y_reg    [NUM_SLOTS];

   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   logic             spawn_fire, spawn_keep;
   logic             upd_valid, catch_hit, retire;
   logic [10:0]      ny, cur_x11;

   logic [NUM_SLOTS-1:0] hit_vec;
   logic [9:0]           dx_arr [NUM_SLOTS];
   logic [9:0]           dy_arr [NUM_SLOTS];
   logic [18:0]          rom_addr_next;
   logic [3:0]           rom_type_next;
   logic                 pixel_hit_next;
   logic [2:0]           count_next;

   logic [18:0] rom_addr_reg;
   logic [3:0]  rom_type_reg, caught_type_reg;
   logic        pixel_hit_reg, caught_valid_reg;
   logic [2:0]  active_count_reg;

   // Lowest-index free slot: scan downwards so the smallest index is written last.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!valid_reg[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   assign spawn_ready = (state_reg == IDLE) && free_found && !frame_tick && !Reset;
   assign spawn_fire  = spawn_valid && spawn_ready;
   assign spawn_keep  = spawn_fire && (spawn_type != 4'd0) && (spawn_type <= 4'd8);

   assign upd_valid = (state_reg == UPDATE) && valid_reg[idx_reg];
   assign ny        = {1'b0, y_reg[idx_reg]} + STEP11;
   assign cur_x11   = {1'b0, x_reg[idx_reg]};
   assign catch_hit = ((ny + SIZE11) >= PADDLE11) && (ny <= PADDLE11) &&
                      ((cur_x11 + SIZE11) > {1'b0, paddle_x}) &&
                      (cur_x11 < ({1'b0, paddle_x} + {1'b0, paddle_w}));
   assign retire    = (ny >= SCREEN11);

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      pending_next = pending_reg;
      case (state_reg)
         IDLE: begin
            if (frame_tick || pending_reg) begin
               state_next   = UPDATE;
               idx_next     = '0;
               pending_next = 1'b0;
            end
         end
         UPDATE: begin
            if (frame_tick) pending_next = 1'b1;
            if (idx_reg == IDX_W'(NUM_SLOTS - 1)) state_next = IDLE;
            else idx_next = idx_reg + IDX_W'(1);
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         pending_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         pending_reg <= pending_next;
      end
   end

   // Spawns only land in IDLE and updates only in UPDATE, so a slot never sees both at once.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         valid_reg <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            type_reg[i] <= '0;
            x_reg[i]    <= '0;
            y_reg[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (spawn_keep && (free_idx == IDX_W'(i))) begin
               valid_reg[i] <= 1'b1;
               type_reg[i]  <= spawn_type;
               x_reg[i]     <= spawn_x;
               y_reg[i]     <= spawn_y;
            end else if (upd_valid && (idx_reg == IDX_W'(i))) begin
               if (catch_hit || retire) valid_reg[i] <= 1'b0;
               else y_reg[i] <= ny[9:0];
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_hit
         assign dx_arr[gi]  = DrawX - x_reg[gi];
         assign dy_arr[gi]  = DrawY - y_reg[gi];
         assign hit_vec[gi] = valid_reg[gi] &&
                              (DrawX >= x_reg[gi]) && ({1'b0, DrawX} < ({1'b0, x_reg[gi]} + SIZE11)) &&
                              (DrawY >= y_reg[gi]) && ({1'b0, DrawY} < ({1'b0, y_reg[gi]} + SIZE11));
      end
   endgenerate

   always_comb begin
      rom_addr_next  = '0;
      rom_type_next  = '0;
      pixel_hit_next = 1'b0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            rom_addr_next  = (19'(dy_arr[i]) * 19'(SPRITE_SIZE)) + 19'(dx_arr[i]);
            rom_type_next  = type_reg[i];
            pixel_hit_next = 1'b1;
         end
      end
   end

   always_comb begin
      count_next = '0;
      for (int i = 0; i < NUM_SLOTS; i++) count_next = count_next + 3'(valid_reg[i]);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rom_addr_reg     <= '0;
         rom_type_reg     <= '0;
         pixel_hit_reg    <= 1'b0;
         caught_valid_reg <= 1'b0;
         caught_type_reg  <= '0;
         active_count_reg <= '0;
      end else begin
         rom_addr_reg     <= rom_addr_next;
         rom_type_reg     <= rom_type_next;
         pixel_hit_reg    <= pixel_hit_next;
         caught_valid_reg <= upd_valid && catch_hit;
         caught_type_reg  <= (upd_valid && catch_hit) ? type_reg[idx_reg] : 4'd0;
         active_count_reg <= count_next;
      end
   end

   assign rom_addr     = rom_addr_reg;
   assign rom_type     = rom_type_reg;
   assign pixel_hit    = pixel_hit_reg;
   assign caught_valid = caught_valid_reg;
   assign caught_type  = caught_type_reg;
   assign active_count = active_count_reg;

endmodule

// File: tb/tb_gadget_sprite_ctrl.sv
// Directed bench for gadget_sprite_ctrl: spawn, pixel lookup, fall/catch/retire,
// slot exhaustion, discarded types, retained frame tick and reset during an update pass.
module tb_gadget_sprite_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        frame_tick = 1'b0;
   logic        spawn_valid = 1'b0;
   logic        spawn_ready;
   logic [3:0]  spawn_type = '0;
   logic [9:0]  spawn_x = '0, spawn_y = '0;
   logic [9:0]  paddle_x = 10'd180, paddle_w = 10'd64;
   logic [9:0]  DrawX = 10'd1023, DrawY = 10'd1023;
   logic [18:0] rom_addr;
   logic [3:0]  rom_type;
   logic        pixel_hit;
   logic        caught_valid;
   logic [3:0]  caught_type;
   logic [2:0]  active_count;

   int vectors = 0;
   int miscompares = 0;

   gadget_sprite_ctrl dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
      .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
      .spawn_type(spawn_type), .spawn_x(spawn_x), .spawn_y(spawn_y),
      .paddle_x(paddle_x), .paddle_w(paddle_w), .DrawX(DrawX), .DrawY(DrawY),
      .rom_addr(rom_addr), .rom_type(rom_type), .pixel_hit(pixel_hit),
      .caught_valid(caught_valid), .caught_type(caught_type), .active_count(active_count)
   );

   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic apply_reset();
      Reset = 1'b1; frame_tick = 1'b0; spawn_valid = 1'b0;
      DrawX = 10'd1023; DrawY = 10'd1023;
      tick(); tick();
      Reset = 1'b0;
      tick();
   endtask

   task automatic spawn(input logic [3:0] t, input logic [9:0] x, input logic [9:0] y);
      spawn_type = t; spawn_x = x; spawn_y = y; spawn_valid = 1'b1;
      tick();
      spawn_valid = 1'b0;
   endtask

   task automatic pixel(input logic [9:0] px, input logic [9:0] py);
      DrawX = px; DrawY = py;
      tick();
   endtask

   // One tick followed by enough cycles for a full update pass to finish.
   task automatic run_frame(output int pulses, output logic [3:0] ctype);
      pulses = 0; ctype = 4'd0;
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (caught_valid) begin pulses++; ctype = caught_type; end
      end
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      #2 Reset = 1'b1;
      #1;
      vectors++; if (spawn_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", spawn_ready); end
      vectors++; if ({rom_addr, rom_type, pixel_hit} !== 24'd0) begin miscompares++; $display("FAIL reset_pixel: got addr=%0d type=%0d hit=%b want 0", rom_addr, rom_type, pixel_hit); end
      vectors++; if ({caught_valid, caught_type, active_count} !== 8'd0) begin miscompares++; $display("FAIL reset_misc: got cv=%b ct=%0d cnt=%0d want 0", caught_valid, caught_type, active_count); end
      tick(); tick();
      Reset = 1'b0;
      tick();
      vectors++; if (spawn_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b want 1", spawn_ready); end
      $display("test_reset done");
   endtask

   task automatic test_spawn();
      apply_reset();
      vectors++; if (spawn_ready !== 1'b1) begin miscompares++; $display("FAIL spawn_ready: got %b want 1", spawn_ready); end
      spawn(4'd3, 10'd100, 10'd50);
      pixel(10'd105, 10'd52);
      vectors++; if (rom_addr !== 19'd69) begin miscompares++; $display("FAIL spawn_addr: got %0d want 69", rom_addr); end
      vectors++; if (rom_type !== 4'd3 || pixel_hit !== 1'b1) begin miscompares++; $display("FAIL spawn_type_hit: got type=%0d hit=%b want 3/1", rom_type, pixel_hit); end
      vectors++; if (active_count !== 3'd1) begin miscompares++; $display("FAIL spawn_count: got %0d want 1", active_count); end
      $display("test_spawn done");
   endtask

   task automatic test_priority();
      apply_reset();
      spawn(4'd1, 10'd300, 10'd100);
      spawn(4'd7, 10'd310, 10'd110);
      pixel(10'd315, 10'd115);
      vectors++; if (rom_type !== 4'd1 || rom_addr !== 19'd495) begin miscompares++; $display("FAIL prio_overlap: got type=%0d addr=%0d want 1/495", rom_type, rom_addr); end
      pixel(10'd340, 10'd138);
      vectors++; if (rom_type !== 4'd7 || rom_addr !== 19'd926) begin miscompares++; $display("FAIL prio_slot1: got type=%0d addr=%0d want 7/926", rom_type, rom_addr); end
      pixel(10'd332, 10'd100);
      vectors++; if ({pixel_hit, rom_type, rom_addr} !== 24'd0) begin miscompares++; $display("FAIL prio_edge_miss: got hit=%b type=%0d addr=%0d want 0", pixel_hit, rom_type, rom_addr); end
      $display("test_priority done");
   endtask

   task automatic test_catch();
      int p; logic [3:0] ct;
      apply_reset();
      paddle_x = 10'd180; paddle_w = 10'd64;
      spawn(4'd5, 10'd200, 10'd404);
      run_frame(p, ct);
      vectors++; if (p !== 0) begin miscompares++; $display("FAIL catch_early: got %0d pulses want 0", p); end
      pixel(10'd201, 10'd407);
      vectors++; if (rom_addr !== 19'd33 || pixel_hit !== 1'b1) begin miscompares++; $display("FAIL catch_fall: got addr=%0d hit=%b want 33/1", rom_addr, pixel_hit); end
      run_frame(p, ct);
      vectors++; if (p !== 1 || ct !== 4'd5) begin miscompares++; $display("FAIL catch_pulse: got pulses=%0d type=%0d want 1/5", p, ct); end
      vectors++; if (active_count !== 3'd0) begin miscompares++; $display("FAIL catch_count: got %0d want 0", active_count); end
      $display("test_catch done");
   endtask

   task automatic test_back_to_back();
      apply_reset();
      spawn(4'd2, 10'd190, 10'd406);
      spawn(4'd8, 10'd210, 10'd406);
      frame_tick = 1'b1; tick(); frame_tick = 1'b0;
      tick();
      vectors++; if (caught_valid !== 1'b1 || caught_type !== 4'd2) begin miscompares++; $display("FAIL b2b_first: got cv=%b type=%0d want 1/2", caught_valid, caught_type); end
      tick();
      vectors++; if (caught_valid !== 1'b1 || caught_type !== 4'd8) begin miscompares++; $display("FAIL b2b_second: got cv=%b type=%0d want 1/8", caught_valid, caught_type); end
      tick();
      vectors++; if (caught_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got cv=%b want 0", caught_valid); end
      tick(); tick();
      $display("test_back_to_back done");
   endtask

   task automatic test_retire();
      int p; logic [3:0] ct;
      apply_reset();
      spawn(4'd2, 10'd0, 10'd478);
      tick();
      vectors++; if (active_count !== 3'd1) begin miscompares++; $display("FAIL retire_pre: got %0d want 1", active_count); end
      run_frame(p, ct);
      vectors++; if (p !== 0 || active_count !== 3'd0) begin miscompares++; $display("FAIL retire: got pulses=%0d cnt=%0d want 0/0", p, active_count); end
      $display("test_retire done");
   endtask

   task automatic test_full();
      int p; logic [3:0] ct;
      apply_reset();
      spawn(4'd1, 10'd400, 10'd10);
      spawn(4'd2, 10'd450, 10'd10);
      spawn(4'd3, 10'd0, 10'd478);
      spawn(4'd4, 10'd500, 10'd10);
      tick();
      vectors++; if (spawn_ready !== 1'b0 || active_count !== 3'd4) begin miscompares++; $display("FAIL full_state: got rdy=%b cnt=%0d want 0/4", spawn_ready, active_count); end
      spawn_type = 4'd6; spawn_x = 10'd600; spawn_y = 10'd200; spawn_valid = 1'b1;
      tick(); tick(); tick();
      spawn_valid = 1'b0;
      pixel(10'd605, 10'd205);
      vectors++; if (pixel_hit !== 1'b0 || active_count !== 3'd4) begin miscompares++; $display("FAIL full_no_overwrite: got hit=%b cnt=%0d want 0/4", pixel_hit, active_count); end
      run_frame(p, ct);
      vectors++; if (active_count !== 3'd3 || spawn_ready !== 1'b1) begin miscompares++; $display("FAIL full_retired: got cnt=%0d rdy=%b want 3/1", active_count, spawn_ready); end
      spawn(4'd6, 10'd600, 10'd200);
      pixel(10'd605, 10'd205);
      vectors++; if (rom_type !== 4'd6 || rom_addr !== 19'd165 || active_count !== 3'd4) begin miscompares++; $display("FAIL full_refill: got type=%0d addr=%0d cnt=%0d want 6/165/4", rom_type, rom_addr, active_count); end
      pixel(10'd405, 10'd15);
      vectors++; if (rom_type !== 4'd1 || rom_addr !== 19'd101) begin miscompares++; $display("FAIL full_slot0_kept: got type=%0d addr=%0d want 1/101", rom_type, rom_addr); end
      $display("test_full done");
   endtask

   task automatic test_bad_type();
      apply_reset();
      vectors++; if (spawn_ready !== 1'b1) begin miscompares++; $display("FAIL bad_ready: got %b want 1", spawn_ready); end
      spawn(4'd0, 10'd100, 10'd100);
      spawn(4'd9, 10'd100, 10'd100);
      tick();
      pixel(10'd101, 10'd101);
      vectors++; if (active_count !== 3'd0 || pixel_hit !== 1'b0) begin miscompares++; $display("FAIL bad_type: got cnt=%0d hit=%b want 0/0", active_count, pixel_hit); end
      $display("test_bad_type done");
   endtask

   task automatic test_pending_tick();
      apply_reset();
      spawn(4'd4, 10'd50, 10'd100);
      frame_tick = 1'b1; tick(); frame_tick = 1'b0;
      tick();
      frame_tick = 1'b1; tick(); frame_tick = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      pixel(10'd50, 10'd103);
      vectors++; if (pixel_hit !== 1'b0) begin miscompares++; $display("FAIL pending_above: got hit=%b want 0", pixel_hit); end
      pixel(10'd50, 10'd104);
      vectors++; if (pixel_hit !== 1'b1 || rom_addr !== 19'd0 || rom_type !== 4'd4) begin miscompares++; $display("FAIL pending_y104: got hit=%b addr=%0d type=%0d want 1/0/4", pixel_hit, rom_addr, rom_type); end
      $display("test_pending_tick done");
   endtask

   task automatic test_reset_mid_update();
      int p;
      apply_reset();
      spawn(4'd1, 10'd0, 10'd10);
      spawn(4'd5, 10'd200, 10'd406);
      pixel(10'd5, 10'd12);
      frame_tick = 1'b1; tick(); frame_tick = 1'b0;
      tick();
      Reset = 1'b1;
      #1;
      vectors++; if ({rom_addr, rom_type, pixel_hit, caught_valid, caught_type, active_count, spawn_ready} !== 33'd0) begin miscompares++; $display("FAIL midreset_zero: got addr=%0d type=%0d hit=%b cv=%b ct=%0d cnt=%0d rdy=%b want 0", rom_addr, rom_type, pixel_hit, caught_valid, caught_type, active_count, spawn_ready); end
      tick();
      Reset = 1'b0;
      p = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (caught_valid) p++;
      end
      vectors++; if (p !== 0) begin miscompares++; $display("FAIL midreset_pulse: got %0d pulses want 0", p); end
      vectors++; if (active_count !== 3'd0 || spawn_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_after: got cnt=%0d rdy=%b want 0/1", active_count, spawn_ready); end
      $display("test_reset_mid_update done");
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_priority();
      test_catch();
      test_back_to_back();
      test_retire();
      test_full();
      test_bad_type();
      test_pending_tick();
      test_reset_mid_update();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
